// File: rtl/snake_dir_input_if.sv
// snake_dir_input_if
// Groups the raw buttons, the game-control strobes and the direction outputs
// of snake_dir_input into one bundle.
//   BtnU/BtnR/BtnD/BtnL : raw push buttons, asynchronous to the clock
//   game_run            : high while the game is in its run state
//   move_tick           : one-cycle movement strobe from the game timer
//   btn_pulse[3:0]      : debounced press pulses {L,D,R,U}
//   dir_out[1:0]        : committed direction (00 up, 01 right, 10 down, 11 left)
//   dir_pending[1:0]    : latched requested direction
//   pending_valid       : dir_pending holds an uncommitted request
//   dir_changed         : one-cycle pulse after dir_out changes
// The master drives buttons and strobes; the slave (the design) drives results.
interface snake_dir_input_if;
  logic       BtnU;
  logic       BtnR;
  logic       BtnD;
  logic       BtnL;
  logic       game_run;
  logic       move_tick;
  logic [3:0] btn_pulse;
  logic [1:0] dir_out;
  logic [1:0] dir_pending;
  logic       pending_valid;
  logic       dir_changed;

  modport master (
    output BtnU, BtnR, BtnD, BtnL, game_run, move_tick,
    input  btn_pulse, dir_out, dir_pending, pending_valid, dir_changed
  );

  modport slave (
    input  BtnU, BtnR, BtnD, BtnL, game_run, move_tick,
    output btn_pulse, dir_out, dir_pending, pending_valid, dir_changed
  );
endinterface

// File: rtl/snake_dir_input.sv
// snake_dir_input
// Turns four raw push buttons into a snake direction. Each button goes
// through a two-flop synchronizer, a counter-based debouncer and a rising
// edge detector that yields a one-cycle press pulse. Press pulses are
// arbitrated (U > R > D > L), filtered against the reference direction
// (no repeats, no 180-degree reversals) and held pending until move_tick
// commits them into dir_out.
// Ports:
//   ClkPort : system clock
//   Reset_n : asynchronous active-low reset
//   bus     : snake_dir_input_if.slave (buttons, game_run, move_tick in;
//             btn_pulse, dir_out, dir_pending, pending_valid, dir_changed out)
// Parameters:
//   DEB_CYCLES : consecutive differing cycles needed to flip a debounced level
//   DEB_W      : debounce counter width, 2**DEB_W > DEB_CYCLES
module snake_dir_input #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input logic              ClkPort,
  input logic              Reset_n,
  snake_dir_input_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [1:0]       DIR_RIGHT = 2'b01;

  // Bit order everywhere below is {L,D,R,U}, so a bit index equals its
  // direction code.
  logic [3:0] raw;

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] deb_prev_q, deb_prev_d;
  logic [3:0] btn_pulse_q, btn_pulse_d;
  logic [DEB_W-1:0] cnt_q [4];
  logic [DEB_W-1:0] cnt_d [4];

  state_e     state_q, state_d;
  logic [1:0] dir_out_q, dir_out_d;
  logic [1:0] dir_pending_q, dir_pending_d;
  logic       dir_changed_q, dir_changed_d;

  logic       req_valid;
  logic [1:0] req_dir;
  logic       commit;
  logic       accept;
  logic [1:0] dir_after;
  logic [1:0] ref_dir;

  assign raw = {bus.BtnL, bus.BtnD, bus.BtnR, bus.BtnU};

  // Front end: synchronize, debounce and edge-detect each button.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // The level flips only after DEB_CYCLES consecutive differing samples.
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // Registered rise detect on the debounced level; releases give nothing.
    btn_pulse_d = deb_q & ~deb_prev_q;
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      btn_pulse_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      btn_pulse_q <= btn_pulse_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Fixed-priority pick among simultaneous pulses; the rest are dropped.
  always_comb begin
    req_valid = 1'b0;
    req_dir   = 2'b00;
    if (btn_pulse_q[0]) begin
      req_valid = 1'b1;
      req_dir   = 2'b00;
    end else if (btn_pulse_q[1]) begin
      req_valid = 1'b1;
      req_dir   = 2'b01;
    end else if (btn_pulse_q[2]) begin
      req_valid = 1'b1;
      req_dir   = 2'b10;
    end else if (btn_pulse_q[3]) begin
      req_valid = 1'b1;
      req_dir   = 2'b11;
    end
  end

  // Request FSM: state register.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request FSM: next state. A request is judged against the direction the
  // snake will have once this cycle settles: the pending one while it is
  // still waiting, otherwise dir_out after any commit in this very cycle.
  always_comb begin
    commit    = (state_q == PEND) && bus.move_tick && bus.game_run;
    dir_after = commit ? dir_pending_q : dir_out_q;
    ref_dir   = ((state_q == PEND) && !bus.move_tick) ? dir_pending_q : dir_after;
    accept    = req_valid && bus.game_run && (req_dir != ref_dir) &&
                ((req_dir ^ ref_dir) != 2'b10);
    state_d   = state_q;
    if (!bus.game_run) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = PEND;
    end else if (commit) begin
      state_d = IDLE;
    end
  end

  // Request FSM: outputs. dir_changed only fires when the commit really
  // moves dir_out, since a pending request can end up equal to dir_out.
  always_comb begin
    dir_out_d     = dir_after;
    dir_pending_d = accept ? req_dir : dir_pending_q;
    dir_changed_d = commit && (dir_pending_q != dir_out_q);
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_out_q     <= DIR_RIGHT;
      dir_pending_q <= DIR_RIGHT;
      dir_changed_q <= 1'b0;
    end else begin
      dir_out_q     <= dir_out_d;
      dir_pending_q <= dir_pending_d;
      dir_changed_q <= dir_changed_d;
    end
  end

  assign bus.btn_pulse     = btn_pulse_q;
  assign bus.dir_out       = dir_out_q;
  assign bus.dir_pending   = dir_pending_q;
  assign bus.pending_valid = (state_q == PEND);
  assign bus.dir_changed   = dir_changed_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// tb_snake_dir_input
// Self-checking bench for snake_dir_input with DEB_CYCLES=4. Direction
// behaviour is driven from a table of press/tick records; press pulses are
// checked by a scoreboard that expects each pulse value at a fixed cycle.
module tb_snake_dir_input;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   passes;

  snake_dir_input_if bus ();

  snake_dir_input #(
    .DEB_CYCLES(4),
    .DEB_W     (4)
  ) dut (
    .ClkPort(clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] mask;
    int         at_cyc;
  } pulse_t;

  typedef struct {
    logic [3:0] btns;
    logic       run;
    logic       tick;
    logic [1:0] exp_dir;
    logic [1:0] exp_pend;
    logic       exp_valid;
    logic       exp_chg;
  } vec_t;

  pulse_t sb_q[$];
  vec_t   vecs[22];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every pulse the design emits must match the oldest expected pulse,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (rst_n && bus.btn_pulse != 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("pulse_unexpected", int'(bus.btn_pulse), 0);
      end else begin
        pulse_t e;
        e = sb_q.pop_front();
        check("pulse_value", int'(bus.btn_pulse), int'(e.mask));
        check("pulse_cycle", cyc, e.at_cyc);
      end
    end
  end

  // Inputs are driven right after the edge at cycle k; the first edge that
  // samples them is edge k+1, and the pulse is visible after 7 edges.
  task automatic driveButtons(input logic [3:0] mask);
    pulse_t e;
    @(posedge clk);
    #1;
    {bus.BtnL, bus.BtnD, bus.BtnR, bus.BtnU} = mask;
    e.mask   = mask;
    e.at_cyc = cyc + 7;
    sb_q.push_back(e);
  endtask

  task automatic releaseButtons(input int hold_done, input int wait_after);
    repeat (hold_done) @(posedge clk);
    #1;
    {bus.BtnL, bus.BtnD, bus.BtnR, bus.BtnU} = 4'b0000;
    repeat (wait_after) @(posedge clk);
  endtask

  task automatic pressButtons(input logic [3:0] mask);
    driveButtons(mask);
    releaseButtons(10, 8);
  endtask

  task automatic doTick(output logic chg);
    @(posedge clk);
    #1;
    bus.move_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.move_tick = 1'b0;
    @(negedge clk);
    chg = bus.dir_changed;
    @(posedge clk);
  endtask

  task automatic checkState(input string tag, input logic [1:0] d, input logic [1:0] p,
                            input logic v);
    @(negedge clk);
    check({tag, "_dir_out"}, int'(bus.dir_out), int'(d));
    check({tag, "_dir_pending"}, int'(bus.dir_pending), int'(p));
    check({tag, "_pending_valid"}, int'(bus.pending_valid), int'(v));
  endtask

  task automatic applyStimulus(input vec_t v, output logic chg);
    @(posedge clk);
    #1;
    bus.game_run = v.run;
    if (v.btns != 4'b0000) pressButtons(v.btns);
    chg = 1'b0;
    if (v.tick) doTick(chg);
    else repeat (2) @(posedge clk);
  endtask

  task automatic checkOutput(input int idx, input vec_t v, input logic chg);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkState(tag, v.exp_dir, v.exp_pend, v.exp_valid);
    check({tag, "_dir_changed"}, int'(chg), int'(v.exp_chg));
  endtask

  initial begin
    logic chg;
    cyc    = 0;
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    {bus.BtnL, bus.BtnD, bus.BtnR, bus.BtnU} = 4'b0000;
    bus.game_run  = 1'b0;
    bus.move_tick = 1'b0;

    //               btns     run  tick dir    pend   valid chg
    vecs[0]  = '{4'b0100, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0};
    vecs[1]  = '{4'b0000, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 1'b1};
    vecs[2]  = '{4'b0010, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1};
    vecs[4]  = '{4'b1000, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{4'b0001, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[6]  = '{4'b1000, 1'b1, 1'b0, 2'b01, 2'b11, 1'b1, 1'b0};
    vecs[7]  = '{4'b0000, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1};
    vecs[8]  = '{4'b0010, 1'b1, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0};
    vecs[9]  = '{4'b0001, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0};
    vecs[10] = '{4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[11] = '{4'b0010, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0};
    vecs[12] = '{4'b0000, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1};
    vecs[13] = '{4'b0101, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[15] = '{4'b0000, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[16] = '{4'b0100, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[17] = '{4'b0000, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[18] = '{4'b0010, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[19] = '{4'b1111, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[20] = '{4'b0100, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[21] = '{4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkState("reset", 2'b01, 2'b01, 1'b0);
    check("reset_btn_pulse", int'(bus.btn_pulse), 0);
    check("reset_dir_changed", int'(bus.dir_changed), 0);

    // Latency: U held 20 cycles gives one pulse 7 edges in, none after.
    $display("[TB] latency check");
    driveButtons(4'b0001);
    releaseButtons(20, 8);

    // Glitch of 3 cycles on R must never debounce.
    $display("[TB] glitch check");
    @(posedge clk);
    #1;
    bus.game_run = 1'b1;
    bus.BtnR     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.BtnR = 1'b0;
    repeat (8) @(posedge clk);
    checkState("glitch", 2'b01, 2'b01, 1'b0);

    $display("[TB] vector table");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i], chg);
      checkOutput(i, vecs[i], chg);
    end

    // Tick and request together while pending: old pending commits, the
    // new request is checked against the new dir_out (U vs R accepted,
    // whereas against the old dir_out U it would be ignored).
    $display("[TB] tick with request in PEND");
    pressButtons(4'b0010);
    checkState("pend_setup", 2'b00, 2'b01, 1'b1);
    driveButtons(4'b0001);
    repeat (7) @(posedge clk);
    #1;
    bus.move_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.move_tick = 1'b0;
    @(negedge clk);
    check("pend_tick_dir_changed", int'(bus.dir_changed), 1);
    releaseButtons(2, 8);
    checkState("pend_tick", 2'b01, 2'b00, 1'b1);
    doTick(chg);
    check("pend_tick2_changed", int'(chg), 1);
    checkState("pend_tick2", 2'b00, 2'b00, 1'b0);

    // Tick and request together while idle: request only becomes pending.
    $display("[TB] tick with request in IDLE");
    driveButtons(4'b0010);
    repeat (7) @(posedge clk);
    #1;
    bus.move_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.move_tick = 1'b0;
    @(negedge clk);
    check("idle_tick_dir_changed", int'(bus.dir_changed), 0);
    releaseButtons(2, 8);
    checkState("idle_tick", 2'b00, 2'b01, 1'b1);
    doTick(chg);
    check("idle_tick2_changed", int'(chg), 1);
    checkState("idle_tick2", 2'b01, 2'b01, 1'b0);

    // Reset mid-operation drops the pending request and a partial debounce.
    $display("[TB] reset mid-operation");
    pressButtons(4'b0001);
    checkState("pre_reset", 2'b01, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    bus.BtnL = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    bus.BtnL = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    checkState("mid_reset", 2'b01, 2'b01, 1'b0);

    repeat (10) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
